// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one ALU among NREQ requesters.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           per-requester handshake (req_ready one-hot, combinational)
//   req_a/req_b/req_instr/req_alusel  packed per-requester operands and op codes
//   alu_a/alu_b/alu_instr/alu_alusel  drive the shared ALU (straight from op registers)
//   alu_y/alu_zero/alu_carry      ALU result
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_y/rsp_zero/rsp_carry/rsp_dz  registered response payload
module alu_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned MULDIV_LAT = 4,
    localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_instr,
    input  logic [NREQ*2-1:0]     req_alusel,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            alu_instr,
    output logic [1:0]            alu_alusel,
    input  logic [WIDTH-1:0]      alu_y,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_y,
    output logic                  rsp_zero,
    output logic                  rsp_carry,
    output logic                  rsp_dz
);

    localparam int unsigned CW = $clog2(MULDIV_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state, state_next;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   idx;
    logic             grant_found;
    logic             accept, exec_last, rsp_take;

    logic [WIDTH-1:0] a_sel, b_sel;
    logic [1:0]       instr_sel, alusel_sel;
    logic             dz_sel;

    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0]       op_instr, op_alusel;
    logic [IDW-1:0]   op_id;
    logic             op_dz;
    logic [CW-1:0]    cnt;

    // Round-robin search starting just after the last served requester
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_id;
        idx         = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last_id) + k) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        a_sel      = '0;
        b_sel      = '0;
        instr_sel  = '0;
        alusel_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                a_sel      = req_a[i*WIDTH +: WIDTH];
                b_sel      = req_b[i*WIDTH +: WIDTH];
                instr_sel  = req_instr[i*2 +: 2];
                alusel_sel = req_alusel[i*2 +: 2];
            end
        end
        dz_sel = (alusel_sel == 2'b01) && instr_sel[0] && (b_sel == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        exec_last  = 1'b0;
        rsp_take   = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_next          = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == CW'(1)) begin
                    exec_last  = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_take   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Op registers and EXEC down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_instr  <= '0;
            op_alusel <= '0;
            op_id     <= '0;
            op_dz     <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            op_a      <= a_sel;
            op_b      <= b_sel;
            op_id     <= grant_id;
            op_dz     <= dz_sel;
            // A trapped divide is replaced by a harmless add so the divider never sees b=0
            op_instr  <= dz_sel ? 2'b00 : instr_sel;
            op_alusel <= dz_sel ? 2'b00 : alusel_sel;
            cnt       <= ((alusel_sel == 2'b01) && !dz_sel) ? CW'(MULDIV_LAT) : CW'(1);
        end else if (state == S_EXEC) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Response registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_dz    <= 1'b0;
            last_id   <= IDW'(NREQ - 1);
        end else if (exec_last) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_y     <= op_dz ? '1   : alu_y;
            rsp_zero  <= op_dz ? 1'b0 : alu_zero;
            rsp_carry <= op_dz ? 1'b0 : alu_carry;
            rsp_dz    <= op_dz;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
            last_id   <= rsp_id;
        end
    end

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_instr  = op_instr;
    assign alu_alusel = op_alusel;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a transaction-level model
// and a small behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ*2-1:0]     req_instr, req_alusel;
    logic [WIDTH-1:0]      alu_a, alu_b, alu_y;
    logic [1:0]            alu_instr, alu_alusel;
    logic                  alu_zero, alu_carry;
    logic                  rsp_valid, rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_zero, rsp_carry, rsp_dz;

    logic [WIDTH-1:0] ra [NREQ];
    logic [WIDTH-1:0] rb [NREQ];
    logic [1:0]       ri [NREQ];
    logic [1:0]       rs [NREQ];

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_instr(req_instr), .req_alusel(req_alusel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr), .alu_alusel(alu_alusel),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_dz(rsp_dz)
    );

    always #5 clk = ~clk;

    // Reference ALU: {carry, y}
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] ins, input logic [1:0] sel);
        logic [32:0] r;
        r = '0;
        case (sel)
            2'b00: case (ins)
                2'b00:   r = {1'b0, a} + {1'b0, b};
                2'b01:   r = {(a < b), a - b};
                2'b10:   r = {1'b0, a & b};
                default: r = {1'b0, a ^ b};
            endcase
            2'b01: case (ins)
                2'b00:   r = {1'b0, 32'($signed(a) * $signed(b))};
                2'b01:   r = (b == 0) ? 33'h0 : {1'b0, 32'($signed(a) / $signed(b))};
                2'b10:   r = {1'b0, 32'(a * b)};
                default: r = (b == 0) ? 33'h0 : {1'b0, a / b};
            endcase
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign {alu_carry, alu_y} = alu_fn(alu_a, alu_b, alu_instr, alu_alusel);
    assign alu_zero = (alu_y == 32'h0);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = ra[i];
            req_b[i*WIDTH +: WIDTH] = rb[i];
            req_instr[i*2 +: 2]     = ri[i];
            req_alusel[i*2 +: 2]    = rs[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Transaction model: one op in flight, response due L cycles after accept
    logic        m_busy = 1'b0;
    int          m_last = NREQ - 1;
    longint      cyc = 0;
    longint      m_rdy = 0;
    int          m_id = 0;
    logic [31:0] m_y, m_a, m_b;
    logic [1:0]  m_ins, m_sel;
    logic        m_zero, m_carry, m_dz;

    always @(posedge clk or negedge rst_n) begin : model_p
        int w;
        int lat;
        logic [32:0] r;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = NREQ - 1;
        end else begin
            if (!m_busy) begin
                w = winner(req_valid, m_last);
                if (w >= 0) begin
                    m_id  = w;
                    m_a   = ra[w];
                    m_b   = rb[w];
                    m_ins = ri[w];
                    m_sel = rs[w];
                    m_dz  = (m_sel == 2'b01) && m_ins[0] && (m_b == 32'h0);
                    if (m_dz) begin
                        m_y = 32'hFFFF_FFFF; m_zero = 1'b0; m_carry = 1'b0; lat = 1;
                    end else begin
                        r = alu_fn(m_a, m_b, m_ins, m_sel);
                        m_y = r[31:0]; m_carry = r[32]; m_zero = (r[31:0] == 32'h0);
                        lat = (m_sel == 2'b01) ? LAT : 1;
                    end
                    m_rdy  = cyc + lat + 1;
                    m_busy = 1'b1;
                end
            end else if (cyc >= m_rdy && rsp_ready) begin
                m_busy = 1'b0;
                m_last = m_id;
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp_p
        logic [NREQ-1:0] er;
        logic ev;
        int w;
        if (rst_n) begin
            er = '0;
            if (!m_busy) begin
                w = winner(req_valid, m_last);
                if (w >= 0) er[w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(er));
            ev = m_busy && (cyc >= m_rdy);
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev) begin
                chk("rsp_id",    64'(rsp_id),    64'(m_id));
                chk("rsp_y",     64'(rsp_y),     64'(m_y));
                chk("rsp_zero",  64'(rsp_zero),  64'(m_zero));
                chk("rsp_carry", 64'(rsp_carry), 64'(m_carry));
                chk("rsp_dz",    64'(rsp_dz),    64'(m_dz));
            end else if (m_busy) begin
                chk("alu_a", 64'(alu_a), 64'(m_a));
                chk("alu_b", 64'(alu_b), 64'(m_b));
                if (!m_dz) begin
                    chk("alu_instr",  64'(alu_instr),  64'(m_ins));
                    chk("alu_alusel", 64'(alu_alusel), 64'(m_sel));
                end
                chk("alu_div_by_zero",
                    64'((alu_alusel == 2'b01) && alu_instr[0] && (alu_b == 32'h0)), 64'(0));
            end
        end
    end

    // Grant log observed on the DUT handshake
    int     grants [$];
    longint gcyc   [$];
    always @(negedge clk) begin
        if (rst_n)
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) begin
                    grants.push_back(i);
                    gcyc.push_back(cyc);
                end
    end

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ins, input logic [1:0] sel,
                         input logic [31:0] ey, input logic ez, input logic ec,
                         input logic ed, input int lat, input string nm);
        int n;
        @(posedge clk); #2;
        ra[id] = a; rb[id] = b; ri[id] = ins; rs[id] = sel;
        req_valid = '0;
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_to({nm, "_grant"});
        @(posedge clk); #2;
        req_valid = '0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_to({nm, "_rsp"});
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_y"},     64'(rsp_y),     64'(ey));
        chk({nm, "_zero"},  64'(rsp_zero),  64'(ez));
        chk({nm, "_carry"}, 64'(rsp_carry), 64'(ec));
        chk({nm, "_dz"},    64'(rsp_dz),    64'(ed));
        chk({nm, "_id"},    64'(rsp_id),    64'(id));
    endtask

    task automatic wait_grants(input int cnt, input string nm);
        int n;
        n = 0;
        while (grants.size() < cnt && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_to(nm);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_rr [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        int n;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; ri[i] = 2'b00; rs[i] = 2'b00;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_y",     64'(rsp_y),     64'(0));
        chk("rst_rsp_id",    64'(rsp_id),    64'(0));
        chk("rst_rsp_dz",    64'(rsp_dz),    64'(0));
        chk("rst_alu_a",     64'(alu_a),     64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst_n = 1'b1;

        do_op(0, 32'd5, 32'd3, 2'b00, 2'b00, 32'd8, 1'b0, 1'b0, 1'b0, 1, "add");
        do_op(2, 32'd7, 32'd7, 2'b01, 2'b00, 32'd0, 1'b1, 1'b0, 1'b0, 1, "zero");
        do_op(3, 32'hFFFF_FFFD, 32'd5, 2'b00, 2'b01, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0, 4, "mul");
        do_op(1, 32'd20, 32'd0, 2'b01, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1, "div0");
        do_op(1, 32'd20, 32'd6, 2'b11, 2'b01, 32'd3, 1'b0, 1'b0, 1'b0, 4, "div");
        do_op(2, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 32'd0, 1'b1, 1'b1, 1'b0, 1, "carry");

        // Round-robin fairness from a fresh reset
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 32'(i + 10); rb[i] = 32'(i); ri[i] = 2'b00; rs[i] = 2'b00;
        end
        grants.delete(); gcyc.delete();
        @(posedge clk); #2 req_valid = 4'hF;
        wait_grants(6, "rr_full");
        @(posedge clk); #2 req_valid = 4'b1101;
        wait_grants(10, "rr_skip");
        @(posedge clk); #2 req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            if (grants.size() > k) chk($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(exp_rr[k]));
            else fail_to($sformatf("rr_grant%0d", k));
        end
        for (int k = 1; k < 10; k++)
            if (gcyc.size() > k) chk($sformatf("rr_spacing%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'(3));
        repeat (6) @(posedge clk);

        // Backpressure: response held, no new grant while waiting
        #2;
        ra[0] = 32'd9; rb[0] = 32'd4; ri[0] = 2'b01; rs[0] = 2'b00;
        rsp_ready = 1'b0;
        grants.delete(); gcyc.delete();
        req_valid = 4'b0001;
        wait_grants(1, "bp_grant");
        @(posedge clk); #2 req_valid = 4'b1110;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_to("bp_rsp");
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid",     64'(rsp_valid), 64'(1));
            chk("bp_y",         64'(rsp_y),     64'(5));
            chk("bp_id",        64'(rsp_id),    64'(0));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        wait_grants(2, "bp_next");
        if (grants.size() > 1) chk("bp_next_id", 64'(grants[1]), 64'(1));
        @(posedge clk); #2 req_valid = '0;
        repeat (6) @(posedge clk);

        // Reset in the middle of a multiply
        #2;
        ra[3] = 32'd6; rb[3] = 32'd7; ri[3] = 2'b00; rs[3] = 2'b01;
        grants.delete(); gcyc.delete();
        req_valid = 4'b1000;
        wait_grants(1, "mr_grant");
        @(posedge clk); #2 req_valid = '0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mr_rsp_y",     64'(rsp_y),     64'(0));
        chk("mr_alu_a",     64'(alu_a),     64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("mr_no_response", 64'(n), 64'(0));
        grants.delete(); gcyc.delete();
        @(posedge clk); #2 req_valid = 4'hF;
        wait_grants(1, "mr_first");
        if (grants.size() > 0) chk("mr_first_id", 64'(grants[0]), 64'(0));
        @(posedge clk); #2 req_valid = '0;
        repeat (8) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance among `NREQ` requesters, such as the fetch/execute units or a test harness. Each operation is granted round-robin, operands are latched, and the shared datapath is sequenced for a single cycle or for `MULDIV_LAT` cycles when the mul/div path is selected. Results are returned with the requester ID over a valid/ready response channel. Divide-by-zero requests are trapped and never reach the ALU divider. The block sits between the requester ports and the ALU, and drives all ALU inputs.

## Interface
- `WIDTH`, 32, operand/result width; must match the attached `alu`.
- `NREQ`, 4, number of requesters (2..8); `IDW` = max(1, $clog2(NREQ)).
- `MULDIV_LAT`, 4, cycles the ALU inputs are held stable for `alusel`=01 (≥1); multicycle-path budget for mul/div.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot grant/accept; transfer when valid&ready.
- `req_a`, `req_b`  in  NREQ*WIDTH each  packed operands, requester i at [i*WIDTH +: WIDTH].
- `req_instr`, `req_alusel`  in  NREQ*2 each  packed op codes, requester i at [i*2 +: 2].
- `alu_a`, `alu_b`  out  WIDTH  to ALU.
- `alu_instr`, `alu_alusel`  out  2  to ALU.
- `alu_y`  in  WIDTH  from ALU.
- `alu_zero`, `alu_carry`  in  1  from ALU.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that issued the op.
- `rsp_y`  out  WIDTH  result.
- `rsp_zero`, `rsp_carry`, `rsp_dz`  out  1  zero flag, ALU carry/overflow flag, divide-by-zero trap.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is set, the winner is the first set bit scanning from `(last_id+1) mod NREQ` upward, with wrap.
  - `req_ready[winner]`=1 combinationally in that cycle only; all other `req_ready` bits are 0.
  - On the accept edge, latch a, b, instr, alusel and id into op registers, then go to EXEC.
  - If no request is valid, all `req_ready` bits are 0.
- **DZ trap:** condition is `alusel`=01 && `instr[0]`=1 && `b`=0.
- **EXEC, non-muldiv ops:** one cycle.
- **EXEC, muldiv ops:** `MULDIV_LAT` cycles, tracked by a down-counter loaded at accept.
- **EXEC, DZ trap:** one cycle. The ALU result is ignored.
- **EXEC completion (last EXEC cycle):**
  - Normal: capture `rsp_y`←`alu_y`, `rsp_zero`←`alu_zero`, `rsp_carry`←`alu_carry`, `rsp_dz`←0, `rsp_id`←op id.
  - DZ trap: `rsp_y`=all-ones, `rsp_zero`=0, `rsp_carry`=0, `rsp_dz`=1.
  - Then go to RESP.
- **RESP:** `rsp_valid`=1 and all `rsp_*` outputs are held stable until `rsp_ready`=1. On that edge, `last_id`←`rsp_id` and the FSM returns to IDLE. No request is accepted while in RESP.
- **ALU inputs:** `alu_*` always reflect the op registers and are stable throughout EXEC. They hold their last value in IDLE and RESP.
- **Flags:** `rsp_carry` is passed through unchanged. The ALU only asserts it for `alusel`=00.
- **Reset (any state, mid-op included):**
  - State, registers and outputs: FSM→IDLE; `last_id`=NREQ-1, so requester 0 has first priority.
  - Op registers: all zero.
  - Response outputs: `rsp_valid`=0 and all `rsp_*`=0.
  - Any in-flight op is discarded with no response.
- **Requester-side rules:** a requester withdrawing `req_valid` while not granted is legal. Request fields only need to be stable in the accept cycle.

## Timing
- Accept at edge T0.
- Result registered at edge T0+L, with L=1 or `MULDIV_LAT`; `rsp_valid` is high from T0+L.
- With `rsp_ready` held high: FSM is back in IDLE after edge T0+L+1, so the next accept occurs at the earliest at edge T0+L+2.
- Throughput: one op per L+2 cycles minimum.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.
- All outputs are registered except `req_ready` and the `alu_*` fan-out, which come from registers.

## Test plan
- **Basic add:** reset, then req0 a=5, b=3, instr=00, alusel=00. Accept edge T0 → `rsp_valid` after edge T0+1 with `rsp_y`=8, `rsp_zero`=0, `rsp_dz`=0, `rsp_id`=0.
- **Zero flag:** req2 a=7, b=7, instr=01, alusel=00 → `rsp_y`=0, `rsp_zero`=1, `rsp_carry`=0, `rsp_id`=2.
- **Round-robin fairness:** all four `req_valid` held high, `rsp_ready`=1 → grants in order 0,1,2,3,0,1, one per 3 cycles. Dropping `req_valid[1]` skips 1 (0,2,3,0).
- **Multiply latency:** `MULDIV_LAT`=4, req3 a=-3, b=5, instr=00, alusel=01 → `alu_*` stable for 4 cycles, `rsp_y`=32'hFFFF_FFF1 after edge T0+4.
- **Divide by zero:** instr=01, alusel=01, b=0 → after edge T0+1, `rsp_dz`=1, `rsp_y`=32'hFFFF_FFFF, `rsp_zero`=0. A following division 20/6 with instr=11 gives `rsp_y`=3 and `rsp_dz`=0.
- **Backpressure and reset:**
  - Hold `rsp_ready`=0 for 3 cycles in RESP → outputs unchanged and `req_ready` all 0.
  - Assert `rst_n`=0 during EXEC of a mul → `rsp_valid` drops immediately and no response is ever issued.
  - After release with all requests valid, requester 0 is granted first.
